pipe_hazard_ctrl: RTL and testbench

Sequential pipeline hazard controller for the 5-stage core. It replaces the purely combinational jump-bubble logic with a single arbiter that decides every cycle which pipeline registers (F/D/E/M/W) stall or bubble. It covers load-use hazards, taken jumps, multi-cycle MUL/DIV in E, data-memory wait states with a timeout watchdog, and trap flushes. It sits beside the stage registers and drives their stall/bubble inputs directly.

---
 rtl/pipe_hazard_ctrl_if.sv | 57 +++++
 rtl/pipe_hazard_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline stages and the hazard controller.
// Defining PIPE_CTRL_PERF_EN adds the stall-cycle and flush-count outputs.
interface pipe_hazard_ctrl_if;
   logic [4:0]  decode_i_rs1;
   logic [4:0]  decode_i_rs2;
   logic        execute_i_is_load;
   logic [4:0]  execute_i_rd;
   logic        execute_i_is_jump;
   logic        execute_i_md_start;
   logic        md_i_done;
   logic        memory_i_req;
   logic        memory_i_ack;
   logic        commit_i_trap;

   logic        ctrl_o_fetch_stall;
   logic        ctrl_o_regD_stall;
   logic        ctrl_o_regE_stall;
   logic        ctrl_o_regM_stall;
   logic        ctrl_o_regW_stall;
   logic        ctrl_o_regD_bubble;
   logic        ctrl_o_regE_bubble;
   logic        ctrl_o_regM_bubble;
   logic        ctrl_o_regW_bubble;
   logic [1:0]  ctrl_o_state;
   logic        ctrl_o_mem_timeout;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] ctrl_o_stall_cycles;
   logic [31:0] ctrl_o_flush_cnt;
`endif

   // The pipeline side drives hazard sources and receives stall/bubble controls.
   modport master (
`ifdef PIPE_CTRL_PERF_EN
      input  ctrl_o_stall_cycles, ctrl_o_flush_cnt,
`endif
      output decode_i_rs1, decode_i_rs2, execute_i_is_load, execute_i_rd,
             execute_i_is_jump, execute_i_md_start, md_i_done,
             memory_i_req, memory_i_ack, commit_i_trap,
      input  ctrl_o_fetch_stall, ctrl_o_regD_stall, ctrl_o_regE_stall,
             ctrl_o_regM_stall, ctrl_o_regW_stall, ctrl_o_regD_bubble,
             ctrl_o_regE_bubble, ctrl_o_regM_bubble, ctrl_o_regW_bubble,
             ctrl_o_state, ctrl_o_mem_timeout
   );

   modport slave (
`ifdef PIPE_CTRL_PERF_EN
      output ctrl_o_stall_cycles, ctrl_o_flush_cnt,
`endif
      input  decode_i_rs1, decode_i_rs2, execute_i_is_load, execute_i_rd,
             execute_i_is_jump, execute_i_md_start, md_i_done,
             memory_i_req, memory_i_ack, commit_i_trap,
      output ctrl_o_fetch_stall, ctrl_o_regD_stall, ctrl_o_regE_stall,
             ctrl_o_regM_stall, ctrl_o_regW_stall, ctrl_o_regD_bubble,
             ctrl_o_regE_bubble, ctrl_o_regM_bubble, ctrl_o_regW_bubble,
             ctrl_o_state, ctrl_o_mem_timeout
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard arbiter: prioritised stall/bubble control for F/D/E/M/W with MUL/DIV,
// dmem-wait watchdog and trap flush sequencing. Optional counters under PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
   parameter int unsigned FLUSH_CYC   = 2,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input logic               clk,
   input logic               rst_n,
   pipe_hazard_ctrl_if.slave hz
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MD_WAIT  = 2'd1,
      MEM_WAIT = 2'd2,
      FLUSH    = 2'd3
   } ctrlState_t;

   localparam logic [3:0] FLUSH_LOAD  = 4'(FLUSH_CYC - 1);
   localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

   ctrlState_t state, nextState;
   logic [3:0] flushCnt, nextFlushCnt;
   logic [7:0] waitCnt, nextWaitCnt;
   logic       timeoutPulse, nextTimeout;

   logic trapCond, memCond, mdCond, jumpCond, loadUseCond;
   logic fetchStall, stallD, stallE, stallM;
   logic bubbleD, bubbleE, bubbleM, bubbleW;
   logic anyStall;

   assign trapCond    = hz.commit_i_trap || (state == FLUSH);
   assign memCond     = hz.memory_i_req && !hz.memory_i_ack;
   assign mdCond      = ((state == RUN) && hz.execute_i_md_start) ||
                        ((state == MD_WAIT) && !hz.md_i_done);
   assign jumpCond    = hz.execute_i_is_jump;
   assign loadUseCond = hz.execute_i_is_load && (hz.execute_i_rd != 5'd0) &&
                        ((hz.execute_i_rd == hz.decode_i_rs1) ||
                         (hz.execute_i_rd == hz.decode_i_rs2));

   // Only the highest-priority hazard shapes the controls; lower ones are masked.
   always_comb begin
      fetchStall = 1'b0;
      stallD     = 1'b0;
      stallE     = 1'b0;
      stallM     = 1'b0;
      bubbleD    = 1'b0;
      bubbleE    = 1'b0;
      bubbleM    = 1'b0;
      bubbleW    = 1'b0;
      if (trapCond) begin
         bubbleD = 1'b1;
         bubbleE = 1'b1;
         bubbleM = 1'b1;
         bubbleW = 1'b1;
      end else if (memCond) begin
         fetchStall = 1'b1;
         stallD     = 1'b1;
         stallE     = 1'b1;
         stallM     = 1'b1;
         bubbleW    = 1'b1;
      end else if (mdCond) begin
         fetchStall = 1'b1;
         stallD     = 1'b1;
         stallE     = 1'b1;
         bubbleM    = 1'b1;
      end else if (jumpCond) begin
         bubbleD = 1'b1;
         bubbleE = 1'b1;
      end else if (loadUseCond) begin
         fetchStall = 1'b1;
         stallD     = 1'b1;
         bubbleE    = 1'b1;
      end
   end

   assign anyStall = fetchStall || stallD || stallE || stallM;

   // A trap wins from any state; a MEM stall seen in MD_WAIT only masks outputs.
   always_comb begin
      nextState    = state;
      nextFlushCnt = flushCnt;
      nextWaitCnt  = waitCnt;
      nextTimeout  = 1'b0;
      if (hz.commit_i_trap) begin
         nextState    = FLUSH;
         nextFlushCnt = FLUSH_LOAD;
      end else begin
         case (state)
            RUN: begin
               if (memCond) begin
                  nextState   = MEM_WAIT;
                  nextWaitCnt = 8'd0;
               end else if (hz.execute_i_md_start) begin
                  nextState = MD_WAIT;
               end
            end
            MD_WAIT: begin
               if (hz.md_i_done) nextState = RUN;
            end
            MEM_WAIT: begin
               if (memCond) begin
                  if (({1'b0, waitCnt} + 9'd1) == TIMEOUT_LIM) begin
                     nextTimeout  = 1'b1;
                     nextState    = FLUSH;
                     nextFlushCnt = FLUSH_LOAD;
                  end else begin
                     nextWaitCnt = waitCnt + 8'd1;
                  end
               end else begin
                  nextState = hz.execute_i_md_start ? MD_WAIT : RUN;
               end
            end
            FLUSH: begin
               if (flushCnt == 4'd0) nextState = RUN;
               else                  nextFlushCnt = flushCnt - 4'd1;
            end
            default: nextState = RUN;
         endcase
      end
   end

   // State, counters and the registered watchdog pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= RUN;
         flushCnt     <= 4'd0;
         waitCnt      <= 8'd0;
         timeoutPulse <= 1'b0;
      end else begin
         state        <= nextState;
         flushCnt     <= nextFlushCnt;
         waitCnt      <= nextWaitCnt;
         timeoutPulse <= nextTimeout;
      end
   end

   assign hz.ctrl_o_fetch_stall = fetchStall;
   assign hz.ctrl_o_regD_stall  = stallD;
   assign hz.ctrl_o_regE_stall  = stallE;
   assign hz.ctrl_o_regM_stall  = stallM;
   assign hz.ctrl_o_regW_stall  = 1'b0;
   assign hz.ctrl_o_regD_bubble = bubbleD;
   assign hz.ctrl_o_regE_bubble = bubbleE;
   assign hz.ctrl_o_regM_bubble = bubbleM;
   assign hz.ctrl_o_regW_bubble = bubbleW;
   assign hz.ctrl_o_state       = state;
   assign hz.ctrl_o_mem_timeout = timeoutPulse;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stallCycles, flushEntries;

   // Saturating counters; re-arming FLUSH from inside FLUSH is not a new entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stallCycles  <= 32'd0;
         flushEntries <= 32'd0;
      end else begin
         if (anyStall && (stallCycles != 32'hFFFF_FFFF))
            stallCycles <= stallCycles + 32'd1;
         if ((nextState == FLUSH) && (state != FLUSH) && (flushEntries != 32'hFFFF_FFFF))
            flushEntries <= flushEntries + 32'd1;
      end
   end

   assign hz.ctrl_o_stall_cycles = stallCycles;
   assign hz.ctrl_o_flush_cnt    = flushEntries;
`else
   logic unusedStall;
   assign unusedStall = anyStall;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (FLUSH_CYC=2, MEM_TIMEOUT=6).
// Define PIPE_CTRL_PERF_EN to also check the performance counters every step.
module tb_pipe_hazard_ctrl;

   localparam int unsigned FLUSH_CYC   = 2;
   localparam int unsigned MEM_TIMEOUT = 6;

   localparam logic [1:0] S_RUN = 2'd0, S_MD = 2'd1, S_MEM = 2'd2, S_FLUSH = 2'd3;
   // Stall packing {F,D,E,M,W}; bubble packing {D,E,M,W}.
   localparam logic [4:0] ST_NONE = 5'b00000, ST_LU = 5'b11000, ST_MD = 5'b11100, ST_MEM = 5'b11110;
   localparam logic [3:0] BB_NONE = 4'b0000, BB_LU = 4'b0100, BB_JUMP = 4'b1100,
                          BB_MD = 4'b0010, BB_MEM = 4'b0001, BB_ALL = 4'b1111;

   typedef struct {
      string      tag;
      logic [1:0] state;
      logic [4:0] stall;
      logic [3:0] bubble;
      logic       timeout;
   } expect_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   expect_t     scoreboard[$];
   int          checkCount = 0;
   int          passCount = 0;
   int          failCount = 0;
   int unsigned expStallTotal = 0;
   int unsigned expFlushTotal = 0;
   logic [1:0]  prevExpState = S_RUN;

   pipe_hazard_ctrl_if hzIf ();

   pipe_hazard_ctrl #(.FLUSH_CYC(FLUSH_CYC), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hzIf)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic idleInputs();
      hzIf.decode_i_rs1       = 5'd0;
      hzIf.decode_i_rs2       = 5'd0;
      hzIf.execute_i_is_load  = 1'b0;
      hzIf.execute_i_rd       = 5'd0;
      hzIf.execute_i_is_jump  = 1'b0;
      hzIf.execute_i_md_start = 1'b0;
      hzIf.md_i_done          = 1'b0;
      hzIf.memory_i_req       = 1'b0;
      hzIf.memory_i_ack       = 1'b0;
      hzIf.commit_i_trap      = 1'b0;
   endtask

   task automatic compareField(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Pops the oldest expectation and compares it with what the DUT shows now.
   task automatic checkOutput();
      expect_t e;
      if (scoreboard.size() == 0) begin
         checkCount++;
         failCount++;
         $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
         return;
      end
      e = scoreboard.pop_front();
      compareField({e.tag, "/state"}, 32'(hzIf.ctrl_o_state), 32'(e.state));
      compareField({e.tag, "/stall"},
                   32'({hzIf.ctrl_o_fetch_stall, hzIf.ctrl_o_regD_stall, hzIf.ctrl_o_regE_stall,
                        hzIf.ctrl_o_regM_stall, hzIf.ctrl_o_regW_stall}), 32'(e.stall));
      compareField({e.tag, "/bubble"},
                   32'({hzIf.ctrl_o_regD_bubble, hzIf.ctrl_o_regE_bubble,
                        hzIf.ctrl_o_regM_bubble, hzIf.ctrl_o_regW_bubble}), 32'(e.bubble));
      compareField({e.tag, "/timeout"}, 32'(hzIf.ctrl_o_mem_timeout), 32'(e.timeout));
`ifdef PIPE_CTRL_PERF_EN
      compareField({e.tag, "/stallCycles"}, hzIf.ctrl_o_stall_cycles, expStallTotal);
      compareField({e.tag, "/flushCnt"}, hzIf.ctrl_o_flush_cnt, expFlushTotal);
`endif
   endtask

   // Inputs are already driven (just after a rising edge); check at the falling edge.
   task automatic applyStimulus(input string tag, input logic [1:0] expState, input logic [4:0] expStall,
                                input logic [3:0] expBubble, input logic expTimeout);
      expect_t e;
      e.tag = tag;
      e.state = expState;
      e.stall = expStall;
      e.bubble = expBubble;
      e.timeout = expTimeout;
      scoreboard.push_back(e);
      if (expState == S_FLUSH && prevExpState != S_FLUSH) expFlushTotal++;
      @(negedge clk);
      checkOutput();
      if (expStall != ST_NONE) expStallTotal++;
      prevExpState = expState;
      @(posedge clk);
      #1;
   endtask

   task automatic resetCheck(input string tag);
      expect_t e;
      rst_n = 1'b0;
      #1;
      expStallTotal = 0;
      expFlushTotal = 0;
      prevExpState = S_RUN;
      e.tag = tag;
      e.state = S_RUN;
      e.stall = ST_NONE;
      e.bubble = BB_NONE;
      e.timeout = 1'b0;
      scoreboard.push_back(e);
      checkOutput();
   endtask

   task automatic releaseReset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      idleInputs();
      #2;
      resetCheck("reset");
      releaseReset();
      applyStimulus("idle", S_RUN, ST_NONE, BB_NONE, 1'b0);

      // Load-use on rs2, then release.
      hzIf.execute_i_is_load = 1'b1; hzIf.execute_i_rd = 5'd5; hzIf.decode_i_rs2 = 5'd5;
      applyStimulus("loaduse_rs2", S_RUN, ST_LU, BB_LU, 1'b0);
      idleInputs();
      applyStimulus("loaduse_release", S_RUN, ST_NONE, BB_NONE, 1'b0);
      hzIf.execute_i_is_load = 1'b1; hzIf.execute_i_rd = 5'd9; hzIf.decode_i_rs1 = 5'd9;
      applyStimulus("loaduse_rs1", S_RUN, ST_LU, BB_LU, 1'b0);
      hzIf.execute_i_rd = 5'd0; hzIf.decode_i_rs1 = 5'd0; hzIf.decode_i_rs2 = 5'd0;
      applyStimulus("loaduse_rd0", S_RUN, ST_NONE, BB_NONE, 1'b0);
      hzIf.execute_i_rd = 5'd5; hzIf.decode_i_rs1 = 5'd3; hzIf.decode_i_rs2 = 5'd4;
      applyStimulus("load_nomatch", S_RUN, ST_NONE, BB_NONE, 1'b0);

      // Jump masks a simultaneous load-use.
      hzIf.execute_i_rd = 5'd7; hzIf.decode_i_rs1 = 5'd7; hzIf.execute_i_is_jump = 1'b1;
      applyStimulus("jump_over_lu", S_RUN, ST_NONE, BB_JUMP, 1'b0);
      idleInputs();
      applyStimulus("jump_release", S_RUN, ST_NONE, BB_NONE, 1'b0);

      // md_i_done outside MD_WAIT is ignored.
      hzIf.md_i_done = 1'b1;
      applyStimulus("done_in_run", S_RUN, ST_NONE, BB_NONE, 1'b0);
      idleInputs();
      applyStimulus("done_ignored", S_RUN, ST_NONE, BB_NONE, 1'b0);

      // MUL/DIV: issue, three waiting cycles, done releases in its own cycle.
      hzIf.execute_i_md_start = 1'b1;
      applyStimulus("md_start", S_RUN, ST_MD, BB_MD, 1'b0);
      idleInputs();
      for (int i = 0; i < 3; i++) applyStimulus("md_wait", S_MD, ST_MD, BB_MD, 1'b0);
      hzIf.md_i_done = 1'b1;
      applyStimulus("md_done", S_MD, ST_NONE, BB_NONE, 1'b0);
      idleInputs();
      applyStimulus("md_back_run", S_RUN, ST_NONE, BB_NONE, 1'b0);

      // dmem wait: 5 stalled cycles, ack on the sixth.
      hzIf.memory_i_req = 1'b1;
      applyStimulus("mem_enter", S_RUN, ST_MEM, BB_MEM, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus("mem_wait", S_MEM, ST_MEM, BB_MEM, 1'b0);
      hzIf.memory_i_ack = 1'b1;
      applyStimulus("mem_ack", S_MEM, ST_NONE, BB_NONE, 1'b0);
      idleInputs();
      applyStimulus("mem_back_run", S_RUN, ST_NONE, BB_NONE, 1'b0);

      // Same-cycle ack: no stall, no state change.
      hzIf.memory_i_req = 1'b1; hzIf.memory_i_ack = 1'b1;
      applyStimulus("mem_fast_ack", S_RUN, ST_NONE, BB_NONE, 1'b0);
      idleInputs();
      applyStimulus("mem_fast_after", S_RUN, ST_NONE, BB_NONE, 1'b0);

      // Watchdog: six MEM_WAIT cycles without ack, then pulse and flush.
      hzIf.memory_i_req = 1'b1;
      applyStimulus("wd_enter", S_RUN, ST_MEM, BB_MEM, 1'b0);
      for (int i = 0; i < MEM_TIMEOUT; i++) applyStimulus("wd_wait", S_MEM, ST_MEM, BB_MEM, 1'b0);
      idleInputs();
      applyStimulus("wd_pulse", S_FLUSH, ST_NONE, BB_ALL, 1'b1);
      applyStimulus("wd_flush2", S_FLUSH, ST_NONE, BB_ALL, 1'b0);
      applyStimulus("wd_back_run", S_RUN, ST_NONE, BB_NONE, 1'b0);

      // Trap during MD_WAIT.
      hzIf.execute_i_md_start = 1'b1;
      applyStimulus("trap_md_start", S_RUN, ST_MD, BB_MD, 1'b0);
      idleInputs();
      applyStimulus("trap_md_wait", S_MD, ST_MD, BB_MD, 1'b0);
      hzIf.commit_i_trap = 1'b1;
      applyStimulus("trap_hit", S_MD, ST_NONE, BB_ALL, 1'b0);
      idleInputs();
      applyStimulus("trap_flush1", S_FLUSH, ST_NONE, BB_ALL, 1'b0);
      applyStimulus("trap_flush2", S_FLUSH, ST_NONE, BB_ALL, 1'b0);
      applyStimulus("trap_back_run", S_RUN, ST_NONE, BB_NONE, 1'b0);

      // Asynchronous reset in the middle of FLUSH.
      hzIf.commit_i_trap = 1'b1;
      applyStimulus("rst_trap", S_RUN, ST_NONE, BB_ALL, 1'b0);
      idleInputs();
      applyStimulus("rst_flush", S_FLUSH, ST_NONE, BB_ALL, 1'b0);
      resetCheck("rst_mid_flush");
      releaseReset();
      applyStimulus("rst_after", S_RUN, ST_NONE, BB_NONE, 1'b0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
